fp_minmax_reduce: RTL

FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

---
 rtl/fp_minmax_reduce.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fp_minmax_reduce.sv
// Streaming min/max reduction over IEEE-754 single or double elements.
// Elements arrive on a valid/ready stream; one result is held until taken.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; no element or result handshakes
// ACCUM | accepting one element per cycle until the counter reaches zero
// DONE  | result presented on out_valid_o until out_ready_i takes it
module fp_minmax_reduce #(
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       fmt_i,
  input  logic [1:0]       op_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [63:0]      in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      out_result_o,
  output logic [4:0]       out_flags_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbl_q, dbl_d;
  logic [1:0]       op_q, op_d;
  logic [63:0]      acc_q, acc_d;
  logic             full_q, full_d;   // accumulator holds a non-NaN element
  logic             nan_q, nan_d;     // NaN seen in a propagating mode
  logic             nv_q, nv_d;

  logic [63:0] elem;
  logic        e_nan, e_snan, e_wins;
  logic [63:0] canon_nan;

  // Map a value onto an unsigned key whose order matches the float order,
  // including -0 below +0. Singles are left-aligned so one compare serves both.
  function automatic logic [63:0] order_key(input logic [63:0] v, input logic dbl);
    logic [63:0] x;
    x = dbl ? v : {v[31:0], 32'h0};
    return x[63] ? ~x : {1'b1, x[62:0]};
  endfunction

  // Element decode against the latched format
  always_comb begin
    elem   = dbl_q ? in_data_i : {32'h0, in_data_i[31:0]};
    e_nan  = 1'b0;
    e_snan = 1'b0;
    if (dbl_q) begin
      e_nan  = (&in_data_i[62:52]) && (|in_data_i[51:0]);
      e_snan = e_nan && !in_data_i[51];
    end else begin
      e_nan  = (&in_data_i[30:23]) && (|in_data_i[22:0]);
      e_snan = e_nan && !in_data_i[22];
    end
    if (op_q[0]) e_wins = order_key(elem, dbl_q) > order_key(acc_q, dbl_q);
    else         e_wins = order_key(elem, dbl_q) < order_key(acc_q, dbl_q);
    canon_nan = dbl_q ? 64'h7ff8000000000000 : 64'h000000007fc00000;
  end

  // Next-state and accumulator update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbl_d   = dbl_q;
    op_d    = op_q;
    acc_d   = acc_q;
    full_d  = full_q;
    nan_d   = nan_q;
    nv_d    = nv_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          dbl_d   = (fmt_i != 2'd0);
          op_d    = op_i;
          cnt_d   = len_i;
          full_d  = 1'b0;
          nan_d   = 1'b0;
          nv_d    = 1'b0;
          state_d = (len_i == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid_i) begin
          nv_d  = nv_q | e_snan;
          cnt_d = cnt_q - 1'b1;
          if (e_nan) begin
            if (op_q[1]) nan_d = 1'b1;
          end else if (!full_q || e_wins) begin
            acc_d  = elem;
            full_d = 1'b1;
          end
          if (cnt_q == 1) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dbl_q   <= 1'b0;
      op_q    <= 2'd0;
      acc_q   <= 64'h0;
      full_q  <= 1'b0;
      nan_q   <= 1'b0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbl_q   <= dbl_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      full_q  <= full_d;
      nan_q   <= nan_d;
      nv_q    <= nv_d;
    end
  end

  // Outputs are decoded from registered state, so the result is stable in DONE
  always_comb begin
    in_ready_o   = (state_q == ACCUM);
    out_valid_o  = (state_q == DONE);
    busy_o       = (state_q != IDLE);
    out_result_o = 64'h0;
    out_flags_o  = 5'h0;
    if (state_q == DONE) begin
      out_result_o = (nan_q || !full_q) ? canon_nan : acc_q;
      out_flags_o  = {nv_q, 4'h0};
    end
  end

endmodule
